// File: rtl/adder_arb_pkg.sv
// -----------------------------------------------------------------------------
// adder_arb_pkg
// Shared definitions for the two-requester shared-adder arbiter:
//   - ADDER_ARB_WIDTH : default operand width in bits
//   - arb_state_e     : result-register occupancy state (EMPTY / FULL)
// -----------------------------------------------------------------------------
package adder_arb_pkg;

    localparam int ADDER_ARB_WIDTH = 4;

    typedef enum logic [0:0] {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } arb_state_e;

endpackage : adder_arb_pkg

// File: rtl/rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
// Two-way round-robin grant selection (purely combinational).
// Ports:
//   valid0, valid1 : requester 0/1 has work
//   last_grant     : requester that won the most recent accepted transfer
//   grant          : requester selected this cycle (0 or 1)
// A lone valid requester always wins. When both or neither are valid the
// requester that did not win last time is chosen, so a grant is always
// pointing somewhere and the ready for it can be raised before valid arrives.
// -----------------------------------------------------------------------------
module rr_arb2 (
    input  logic valid0,
    input  logic valid1,
    input  logic last_grant,
    output logic grant
);

    // Select the winning requester from the valids and round-robin history
    always_comb begin
        grant = 1'b0;
        case ({valid1, valid0})
            2'b01:   grant = 1'b0;
            2'b10:   grant = 1'b1;
            2'b11:   grant = ~last_grant;
            2'b00:   grant = ~last_grant;
            default: grant = 1'b0;
        endcase
    end

endmodule : rr_arb2

// File: rtl/adder_rr_arbiter.sv
// -----------------------------------------------------------------------------
// adder_rr_arbiter
// Two requesters share one WIDTH-bit adder. A single result register holds at
// most one result; a new operand pair is accepted whenever the register is
// empty or is being drained in the same cycle, giving one result per cycle
// under sustained load.
//
// Parameters:
//   WIDTH                  : operand width (default from adder_arb_pkg)
// Ports:
//   clk                    : clock, all state on rising edge
//   rst                    : synchronous active-high reset
//   req0_valid/req1_valid  : requester has an operand pair
//   req0_ready/req1_ready  : requester's pair is accepted this cycle (comb)
//   req0_a/b, req1_a/b     : operands
//   rsp_valid              : result register holds a result
//   rsp_ready              : consumer takes the result this cycle
//   rsp_id                 : requester that produced the held result
//   rsp_sum                : registered a+b, WIDTH+1 bits
//
// Build option:
//   ADDER_ARB_SATURATE_EN  : when defined, sums above 2^WIDTH-1 clip to
//                            2^WIDTH-1 (carry bit forced to 0).
// -----------------------------------------------------------------------------
module adder_rr_arbiter
    import adder_arb_pkg::*;
#(
    parameter int WIDTH = ADDER_ARB_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH:0]   rsp_sum
);

    arb_state_e       state_r;
    arb_state_e       state_next_s;
    logic             last_grant_r;
    logic             grant_s;
    logic             open_s;
    logic             accept_s;
    logic [WIDTH-1:0] op_a_s;
    logic [WIDTH-1:0] op_b_s;
    logic [WIDTH:0]   sum_full_s;
    logic [WIDTH:0]   sum_s;
    logic [WIDTH:0]   rsp_sum_r;
    logic             rsp_id_r;

    rr_arb2 u_rr_arb2 (
        .valid0     (req0_valid),
        .valid1     (req1_valid),
        .last_grant (last_grant_r),
        .grant      (grant_s)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= EMPTY;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next state: fill on accept, empty on drain without a refill
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            EMPTY: begin
                if (accept_s) begin
                    state_next_s = FULL;
                end else begin
                    state_next_s = EMPTY;
                end
            end
            FULL: begin
                if (accept_s) begin
                    state_next_s = FULL;
                end else if (rsp_ready) begin
                    state_next_s = EMPTY;
                end else begin
                    state_next_s = FULL;
                end
            end
            default: state_next_s = EMPTY;
        endcase
    end

    // FSM outputs: accept window, per-requester readies, response valid
    always_comb begin
        open_s     = 1'b0;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        case (state_r)
            EMPTY:   open_s = 1'b1;
            FULL:    open_s = rsp_ready;
            default: open_s = 1'b0;
        endcase
        rsp_valid = (state_r == FULL);
        // Readies are masked during reset so no transfer is seen as accepted
        if (rst) begin
            req0_ready = 1'b0;
            req1_ready = 1'b0;
        end else begin
            req0_ready = open_s && (grant_s == 1'b0);
            req1_ready = open_s && (grant_s == 1'b1);
        end
    end

    // A transfer happens only when the granted requester is also valid
    always_comb begin
        accept_s = (req0_valid && req0_ready) || (req1_valid && req1_ready);
    end

    // Route the granted requester's operands into the shared adder
    always_comb begin
        if (grant_s) begin
            op_a_s = req1_a;
            op_b_s = req1_b;
        end else begin
            op_a_s = req0_a;
            op_b_s = req0_b;
        end
    end

    // Shared adder, with optional clipping of the carry-out case
    always_comb begin
        sum_full_s = {1'b0, op_a_s} + {1'b0, op_b_s};
`ifdef ADDER_ARB_SATURATE_EN
        if (sum_full_s[WIDTH]) begin
            sum_s = {1'b0, {WIDTH{1'b1}}};
        end else begin
            sum_s = sum_full_s;
        end
`else
        sum_s = sum_full_s;
`endif
    end

    // Result register and round-robin history; both move only on an accept
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_sum_r    <= {(WIDTH+1){1'b0}};
            rsp_id_r     <= 1'b0;
            last_grant_r <= 1'b1;
        end else if (accept_s) begin
            rsp_sum_r    <= sum_s;
            rsp_id_r     <= grant_s;
            last_grant_r <= grant_s;
        end else begin
            rsp_sum_r    <= rsp_sum_r;
            rsp_id_r     <= rsp_id_r;
            last_grant_r <= last_grant_r;
        end
    end

    // Drive response outputs straight from their registers
    always_comb begin
        rsp_sum = rsp_sum_r;
        rsp_id  = rsp_id_r;
    end

endmodule : adder_rr_arbiter

// File: tb/tb_adder_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_adder_rr_arbiter
// Directed scenarios followed by random traffic, every cycle checked against a
// small transaction-level reference model of the arbiter.
// -----------------------------------------------------------------------------
module tb_adder_rr_arbiter;

    localparam int W   = 4;
    localparam int MAX = (1 << W) - 1;

    logic         clk;
    logic         rst;
    logic         req0_valid, req1_valid;
    logic         req0_ready, req1_ready;
    logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
    logic         rsp_valid, rsp_ready, rsp_id;
    logic [W:0]   rsp_sum;

    int total;
    int bad;

    // Reference model: contents of the one-deep result slot plus RR history
    bit m_full;
    int m_sum;
    int m_id;
    int m_last;
    int m_grant;
    bit m_r0, m_r1;

    adder_rr_arbiter #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_sum    (rsp_sum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int ref_sum(input int a, input int b);
        int s;
        s = a + b;
`ifdef ADDER_ARB_SATURATE_EN
        if (s > MAX) s = MAX;
`endif
        return s;
    endfunction

    // One clock: check readies mid-cycle, advance model at the edge, check
    // the registered response just after the edge.
    task automatic step();
        bit acc;
        @(negedge clk);
        if (req0_valid && !req1_valid)      m_grant = 0;
        else if (req1_valid && !req0_valid) m_grant = 1;
        else                                m_grant = 1 - m_last;
        m_r0 = !rst && (!m_full || rsp_ready) && (m_grant == 0);
        m_r1 = !rst && (!m_full || rsp_ready) && (m_grant == 1);
        chk("req0_ready", int'(req0_ready), int'(m_r0));
        chk("req1_ready", int'(req1_ready), int'(m_r1));
        @(posedge clk);
        if (rst) begin
            m_full = 1'b0; m_sum = 0; m_id = 0; m_last = 1;
        end else begin
            acc = (req0_valid && m_r0) || (req1_valid && m_r1);
            if (acc) begin
                m_full = 1'b1;
                m_id   = m_grant;
                m_last = m_grant;
                m_sum  = (m_grant == 0) ? ref_sum(int'(req0_a), int'(req0_b))
                                        : ref_sum(int'(req1_a), int'(req1_b));
            end else if (rsp_ready) begin
                m_full = 1'b0;
            end
        end
        #1;
        chk("rsp_valid", int'(rsp_valid), int'(m_full));
        chk("rsp_sum", int'(rsp_sum), m_sum);
        chk("rsp_id", int'(rsp_id), m_id);
    endtask

    initial begin
        total = 0; bad = 0;
        m_full = 1'b0; m_sum = 0; m_id = 0; m_last = 1; m_grant = 0;
        rst = 1'b1; rsp_ready = 1'b0;
        req0_valid = 1'b1; req1_valid = 1'b1;
        req0_a = 4'd3; req0_b = 4'd4; req1_a = 4'd5; req1_b = 4'd6;

        // Reset held two cycles with both requesters valid
        step(); step();
        chk("rst_valid", int'(rsp_valid), 0);
        chk("rst_sum", int'(rsp_sum), 0);

        // Contention: alternating id0/id1 results, one per cycle
        rst = 1'b0; rsp_ready = 1'b1;
        #1;
        chk("first_ready0", int'(req0_ready), 1);
        for (int i = 0; i < 6; i++) begin
            step();
            chk("cont_id", int'(rsp_id), i % 2);
            chk("cont_sum", int'(rsp_sum), (i % 2 == 1) ? 11 : 7);
        end

        // Backpressure: hold (2,2) result for three cycles, then drain+accept
        req0_valid = 1'b1; req1_valid = 1'b0; req0_a = 4'd2; req0_b = 4'd2;
        step();
        rsp_ready = 1'b0; req0_valid = 1'b0; req1_valid = 1'b1;
        req1_a = 4'd7; req1_b = 4'd1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("bp_sum", int'(rsp_sum), 4);
            chk("bp_id", int'(rsp_id), 0);
            chk("bp_ready1", int'(req1_ready), 0);
        end
        rsp_ready = 1'b1;
        step();
        chk("bp_drain_id", int'(rsp_id), 1);
        chk("bp_drain_sum", int'(rsp_sum), 8);

        // Overflow on requester 1
        req1_a = 4'd15; req1_b = 4'd15;
        step();
`ifdef ADDER_ARB_SATURATE_EN
        chk("ovf_sum", int'(rsp_sum), 15);
`else
        chk("ovf_sum", int'(rsp_sum), 30);
`endif

        // Single requester 1 for four transfers, then contention favours 0
        for (int i = 0; i < 4; i++) begin
            req1_a = W'($urandom_range(0, MAX));
            req1_b = W'($urandom_range(0, MAX));
            step();
            chk("single_id", int'(rsp_id), 1);
        end
        req0_valid = 1'b1; req0_a = 4'd1; req0_b = 4'd9;
        step();
        chk("after_single_id", int'(rsp_id), 0);
        chk("after_single_sum", int'(rsp_sum), 10);

        // Mid-operation reset discards the held result
        rsp_ready = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
        step();
        chk("midrst_valid", int'(rsp_valid), 0);
        chk("midrst_sum", int'(rsp_sum), 0);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            req0_valid = 1'($urandom_range(0, 1));
            req1_valid = 1'($urandom_range(0, 1));
            rsp_ready  = ($urandom_range(0, 3) != 0);
            rst        = ($urandom_range(0, 60) == 0);
            req0_a = W'($urandom_range(0, MAX));
            req0_b = W'($urandom_range(0, MAX));
            req1_a = W'($urandom_range(0, MAX));
            req1_b = W'($urandom_range(0, MAX));
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_adder_rr_arbiter

// File: doc/adder_rr_arbiter.md
ADDER_RR_ARBITER -- requirements
Module: adder_rr_arbiter

Interface
REQ-001 Parameter: WIDTH, default 4, operand width in bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 req0_valid / req1_valid  input  1 each  requester 0/1 has an operand pair.
REQ-005 req0_ready / req1_ready  output  1 each  requester 0/1 pair is accepted this cycle.
REQ-006 req0_a, req0_b, req1_a, req1_b  input  WIDTH each  operands.
REQ-007 rsp_valid  output  1  result register holds a valid result.
REQ-008 rsp_ready  input  1  consumer accepts the result this cycle.
REQ-009 rsp_id  output  1  requester that produced the held result.
REQ-010 rsp_sum  output  WIDTH+1  registered a+b including carry.

Function
REQ-011 Shall share one WIDTH-bit adder between two requesters, with one result register (one transaction in flight).
REQ-012 FSM: EMPTY (no result held) and FULL (result held); EMPTY->FULL on accept; FULL->EMPTY on rsp_valid&&rsp_ready without accept; FULL->FULL on drain and accept in the same cycle.
REQ-013 Accept-enable: open = (state==EMPTY) || rsp_ready; reqN_ready = open && grant==N; reqN_ready is combinational and independent of reqN_valid.
REQ-014 Grant, round-robin: one valid requester is granted; both valid grants the requester not in last_grant; neither valid grants the requester not in last_grant.
REQ-015 last_grant updates only on an accept (reqN_valid && reqN_ready), never on an idle cycle.
REQ-016 Accept at edge k: rsp_valid=1, rsp_sum and rsp_id updated at edge k (visible cycle k+1); latency one cycle.
REQ-017 While FULL and rsp_ready=0: rsp_sum, rsp_id, rsp_valid shall hold stable and both reqN_ready shall be 0.
REQ-018 Back-to-back: drain and accept in the same cycle; sustained throughput one result per cycle.
REQ-019 Arithmetic: rsp_sum = zero-extended a + zero-extended b, WIDTH+1 bits, no truncation.

Reset
REQ-020 rst=1 at an edge: state=EMPTY, rsp_valid=0, rsp_sum=0, rsp_id=0, last_grant=1 (requester 0 wins first contention).
REQ-021 Reset mid-operation discards any held result; no accept occurs in a cycle where rst=1; reqN_ready shall be 0 while rst=1.

Configuration
REQ-022 Macro ADDER_ARB_SATURATE_EN defined: rsp_sum shall clip to 2^WIDTH-1 (carry bit 0) when the true sum exceeds 2^WIDTH-1.
REQ-023 Macro undefined: rsp_sum is the full WIDTH+1-bit sum per REQ-019; no other behaviour differs.

Structure
REQ-024 Package adder_arb_pkg shall hold the WIDTH default constant and the FSM state enum (EMPTY, FULL).
REQ-025 Grant logic shall be one sub-module, rr_arb2 (inputs: two valids, last_grant; output: grant); adder, result register and FSM stay in adder_rr_arbiter.

Verification
REQ-026 Reset: hold rst 2 cycles with both valids high -> rsp_valid=0, rsp_sum=0, req0_ready=req1_ready=0; first cycle after release req0_ready=1.
REQ-027 Contention: both valid continuously, rsp_ready=1, req0=(3,4), req1=(5,6) -> rsp alternates id0 sum 7, id1 sum 11, one result per cycle, starting with id0.
REQ-028 Backpressure: req0=(2,2) accepted, rsp_ready=0 for 3 cycles -> rsp_sum=4, rsp_id=0 stable, both readies 0; rsp_ready=1 -> drain plus new accept in the same cycle.
REQ-029 Overflow: req1=(15,15) -> rsp_sum=30 (5'h1E) without the macro; rsp_sum=15 (5'h0F) with ADDER_ARB_SATURATE_EN.
REQ-030 Single requester: only req1 valid for 4 transactions -> all granted to id1, last_grant=1; req0 then asserted alongside req1 -> req0 granted first.
REQ-031 Mid-op reset: result held with rsp_ready=0, pulse rst 1 cycle -> next cycle rsp_valid=0 and no stale result ever appears on the output.
